// File: rtl/ic_port_arbiter.sv
// ic_port_arbiter: two-to-one arbiter sharing one req/gnt/recv/ack target port
// between two requesters (port 0 = CPU data, port 1 = CPU instruction).
// Exactly one transaction is outstanding at the target. The response is
// routed back to the owning requester.
//
// Ports:
//   g_clk, g_resetn         clock, async active-low reset
//   p{0,1}_req/wen/strb/wdata/addr   requester request channel (in)
//   p{0,1}_gnt                       request accepted (out)
//   p{0,1}_recv/error/rdata          response channel (out)
//   p{0,1}_ack                       requester accepts response (in)
//   s_req/wen/strb/wdata/addr        request to shared target (out)
//   s_gnt, s_recv, s_error, s_rdata  target grant and response (in)
//   s_ack                            response ack to target (out)
//   busy                             high whenever state is not IDLE
//
// Configuration macro: IC_ARB_ROUND_ROBIN_EN
//   defined   -> contention in IDLE is won by the port not equal to `last`
//   undefined -> fixed priority, port 0 wins contention
//
// Request and response paths are combinational (zero added cycles). All
// outputs are forced low while g_resetn is asserted.

module ic_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            p0_req,
  input  logic            p0_wen,
  input  logic [DW/8-1:0] p0_strb,
  input  logic [DW-1:0]   p0_wdata,
  input  logic [AW-1:0]   p0_addr,
  output logic            p0_gnt,
  output logic            p0_recv,
  input  logic            p0_ack,
  output logic            p0_error,
  output logic [DW-1:0]   p0_rdata,

  input  logic            p1_req,
  input  logic            p1_wen,
  input  logic [DW/8-1:0] p1_strb,
  input  logic [DW-1:0]   p1_wdata,
  input  logic [AW-1:0]   p1_addr,
  output logic            p1_gnt,
  output logic            p1_recv,
  input  logic            p1_ack,
  output logic            p1_error,
  output logic [DW-1:0]   p1_rdata,

  output logic            s_req,
  output logic            s_wen,
  output logic [DW/8-1:0] s_strb,
  output logic [DW-1:0]   s_wdata,
  output logic [AW-1:0]   s_addr,
  input  logic            s_gnt,
  input  logic            s_recv,
  input  logic            s_error,
  input  logic [DW-1:0]   s_rdata,
  output logic            s_ack,

  output logic            busy
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last;

  logic   both_win_c;
  logic   win_c;
  logic   sel_c;
  logic   sel_req_c;
  logic   fwd_c;
  logic   gnt_c;
  logic   rsp_c;
  logic   own_ack_c;

  // Contention resolution between two simultaneous IDLE requests
`ifdef IC_ARB_ROUND_ROBIN_EN
  assign both_win_c = ~last;
`else
  logic last_unused;
  assign both_win_c  = 1'b0;
  assign last_unused = last;
`endif

  // Winner in IDLE; selection locked to owner in REQ/RSP
  always_comb begin
    win_c = 1'b0;
    if (p0_req && p1_req) begin
      win_c = both_win_c;
    end else begin
      win_c = p1_req;
    end
    sel_c = (state == IDLE) ? win_c : owner;
  end

  assign sel_req_c = sel_c ? p1_req : p0_req;
  // In IDLE the winner is always a requester, so sel_req_c covers both cases
  assign fwd_c     = g_resetn && (state != RSP) && sel_req_c;
  assign gnt_c     = fwd_c && s_gnt;
  assign rsp_c     = g_resetn && (state == RSP);
  assign own_ack_c = owner ? p1_ack : p0_ack;

  // Forward request to the target; payload zeroed when no request
  always_comb begin
    s_req   = fwd_c;
    s_wen   = 1'b0;
    s_strb  = SW'(0);
    s_wdata = DW'(0);
    s_addr  = AW'(0);
    if (fwd_c) begin
      s_wen   = sel_c ? p1_wen   : p0_wen;
      s_strb  = sel_c ? p1_strb  : p0_strb;
      s_wdata = sel_c ? p1_wdata : p0_wdata;
      s_addr  = sel_c ? p1_addr  : p0_addr;
    end
  end

  // Grants and responses go to the selected / owning port only
  always_comb begin
    p0_gnt   = gnt_c && !sel_c;
    p1_gnt   = gnt_c &&  sel_c;
    p0_recv  = 1'b0;
    p0_error = 1'b0;
    p0_rdata = DW'(0);
    p1_recv  = 1'b0;
    p1_error = 1'b0;
    p1_rdata = DW'(0);
    s_ack    = rsp_c && own_ack_c;
    if (rsp_c && !owner) begin
      p0_recv  = s_recv;
      p0_error = s_error;
      p0_rdata = s_rdata;
    end
    if (rsp_c && owner) begin
      p1_recv  = s_recv;
      p1_error = s_error;
      p1_rdata = s_rdata;
    end
  end

  assign busy = (state != IDLE);

  // Transaction state machine
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sel_req_c) begin
            owner <= win_c;
            if (s_gnt) begin
              last  <= win_c;
              state <= RSP;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (!sel_req_c) begin
            state <= IDLE;
          end else if (s_gnt) begin
            last  <= owner;
            state <= RSP;
          end
        end
        RSP: begin
          if (s_recv && s_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_port_arbiter.sv
// Self-checking bench for ic_port_arbiter. Expected grants and responses are
// queued when stimulus is driven and compared by a monitor when they appear.

module tb_ic_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          g_clk;
  logic          g_resetn;
  logic          p0_req, p0_wen, p0_gnt, p0_recv, p0_ack, p0_error;
  logic [SW-1:0] p0_strb;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic [AW-1:0] p0_addr;
  logic          p1_req, p1_wen, p1_gnt, p1_recv, p1_ack, p1_error;
  logic [SW-1:0] p1_strb;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] p1_addr;
  logic          s_req, s_wen, s_gnt, s_recv, s_error, s_ack;
  logic [SW-1:0] s_strb;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [AW-1:0] s_addr;
  logic          busy;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic gnt_q[$];
  rsp_t rsp_q[$];
  int   checks;
  int   errors;

  ic_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_strb(p0_strb), .p0_wdata(p0_wdata),
    .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_recv(p0_recv), .p0_ack(p0_ack),
    .p0_error(p0_error), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_strb(p1_strb), .p1_wdata(p1_wdata),
    .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_recv(p1_recv), .p1_ack(p1_ack),
    .p1_error(p1_error), .p1_rdata(p1_rdata),
    .s_req(s_req), .s_wen(s_wen), .s_strb(s_strb), .s_wdata(s_wdata),
    .s_addr(s_addr), .s_gnt(s_gnt), .s_recv(s_recv), .s_error(s_error),
    .s_rdata(s_rdata), .s_ack(s_ack), .busy(busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Scoreboard monitor: pops expectations when the DUT grants or hands back a response
  always @(negedge g_clk) begin
    logic got_port;
    logic exp_port;
    rsp_t exp_r;
    rsp_t got_r;
    if (g_resetn) begin
      if (p0_gnt || p1_gnt) begin
        checks++;
        got_port = p1_gnt;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: p0_gnt=%0b p1_gnt=%0b required none", p0_gnt, p1_gnt);
        end else begin
          exp_port = gnt_q.pop_front();
          if ((p0_gnt && p1_gnt) || got_port !== exp_port) begin
            errors++;
            $display("FAIL grant_port: p0_gnt=%0b p1_gnt=%0b required port %0d", p0_gnt, p1_gnt, exp_port);
          end
        end
      end
      if ((p0_recv && p0_ack) || (p1_recv && p1_ack)) begin
        checks++;
        got_r.port  = p1_recv;
        got_r.rdata = p1_recv ? p1_rdata : p0_rdata;
        got_r.err   = p1_recv ? p1_error : p0_error;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: port=%0d rdata=%h required none", got_r.port, got_r.rdata);
        end else begin
          exp_r = rsp_q.pop_front();
          if ((p0_recv && p1_recv) || got_r !== exp_r) begin
            errors++;
            $display("FAIL rsp_data: port=%0d rdata=%h err=%0b required port=%0d rdata=%h err=%0b",
                     got_r.port, got_r.rdata, got_r.err, exp_r.port, exp_r.rdata, exp_r.err);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 1'b0; p0_wen = 1'b0; p0_strb = '0; p0_wdata = '0; p0_addr = '0; p0_ack = 1'b0;
    p1_req = 1'b0; p1_wen = 1'b0; p1_strb = '0; p1_wdata = '0; p1_addr = '0; p1_ack = 1'b0;
    s_gnt = 1'b0; s_recv = 1'b0; s_error = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    g_resetn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    g_resetn = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; s_gnt = 1'b1; s_recv = 1'b1;
    p0_ack = 1'b1; p1_ack = 1'b1; p0_addr = 32'h1234_5678; s_rdata = 32'hFFFF_FFFF;
    #3;
    checks++;
    if ({busy, s_req, s_ack, p0_gnt, p1_gnt, p0_recv, p1_recv} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/s_req/s_ack/gnt/recv=%b required 0000000",
               {busy, s_req, s_ack, p0_gnt, p1_gnt, p0_recv, p1_recv});
    end
    checks++;
    if (s_addr !== 32'h0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: s_addr=%h p0_rdata=%h p1_rdata=%h required 0", s_addr, p0_rdata, p1_rdata);
    end
    cyc();
    clear_inputs();
    g_resetn = 1'b1;
    cyc();
  endtask

  task automatic test_single_read_p1();
    p1_req = 1'b1; p1_addr = 32'h2000_0010; s_gnt = 1'b1;
    gnt_q.push_back(1'b1);
    #3;
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h2000_0010) begin
      errors++;
      $display("FAIL single_fwd: s_req=%0b s_addr=%h required 1 20000010", s_req, s_addr);
    end
    checks++;
    if (p1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt: p1_gnt=%0b required 1", p1_gnt);
    end
    cyc();
    p1_req = 1'b0; s_gnt = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b1 || p1_recv !== 1'b0 || p0_recv !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: busy=%0b p1_recv=%0b p0_recv=%0b required 1 0 0", busy, p1_recv, p0_recv);
    end
    cyc();
    s_recv = 1'b1; s_rdata = 32'hDEAD_BEEF; p1_ack = 1'b1;
    rsp_q.push_back('{port: 1'b1, rdata: 32'hDEAD_BEEF, err: 1'b0});
    #3;
    checks++;
    if (p1_recv !== 1'b1 || p1_rdata !== 32'hDEAD_BEEF || p0_recv !== 1'b0 || s_ack !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp: p1_recv=%0b p1_rdata=%h p0_recv=%0b s_ack=%0b required 1 deadbeef 0 1",
               p1_recv, p1_rdata, p0_recv, s_ack);
    end
    cyc();
    s_recv = 1'b0; s_rdata = '0; p1_ack = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%0b required 0", busy);
    end
    cyc();
  endtask

  task automatic test_stalled_lock();
    p1_req = 1'b1; p1_addr = 32'h1000_0040;
    p0_addr = 32'h3000_0000; p0_wen = 1'b1; p0_wdata = 32'hA5A5_5A5A; p0_strb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) p0_req = 1'b1;
      #3;
      checks++;
      if (s_addr !== 32'h1000_0040 || s_wen !== 1'b0 || p1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL lock_stall%0d: s_addr=%h s_wen=%0b p1_gnt=%0b required 10000040 0 0",
                 c, s_addr, s_wen, p1_gnt);
      end
      cyc();
    end
    s_gnt = 1'b1;
    gnt_q.push_back(1'b1);
    #3;
    checks++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || s_addr !== 32'h1000_0040) begin
      errors++;
      $display("FAIL lock_gnt: p1_gnt=%0b p0_gnt=%0b s_addr=%h required 1 0 10000040", p1_gnt, p0_gnt, s_addr);
    end
    cyc();
    p1_req = 1'b0;
    #3;
    checks++;
    if (s_req !== 1'b0 || p0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_rsp_nogrant: s_req=%0b p0_gnt=%0b required 0 0", s_req, p0_gnt);
    end
    cyc();
    s_gnt = 1'b0; s_recv = 1'b1; s_rdata = 32'h1111_2222; p1_ack = 1'b1;
    rsp_q.push_back('{port: 1'b1, rdata: 32'h1111_2222, err: 1'b0});
    cyc();
    s_recv = 1'b0; p1_ack = 1'b0; s_gnt = 1'b1;
    gnt_q.push_back(1'b0);
    #3;
    checks++;
    if (p0_gnt !== 1'b1 || s_addr !== 32'h3000_0000 || s_wdata !== 32'hA5A5_5A5A || s_wen !== 1'b1) begin
      errors++;
      $display("FAIL lock_p0_after: p0_gnt=%0b s_addr=%h s_wdata=%h s_wen=%0b required 1 30000000 a5a55a5a 1",
               p0_gnt, s_addr, s_wdata, s_wen);
    end
    cyc();
    p0_req = 1'b0; s_gnt = 1'b0; s_recv = 1'b1; s_rdata = 32'h3333_4444; p0_ack = 1'b1;
    rsp_q.push_back('{port: 1'b0, rdata: 32'h3333_4444, err: 1'b0});
    cyc();
    clear_inputs();
    #3;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle: busy=%0b required 0", busy);
    end
    cyc();
  endtask

  task automatic test_contention();
    logic [3:0] order;
`ifdef IC_ARB_ROUND_ROBIN_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    do_reset();
    p0_req = 1'b1; p0_addr = 32'h0000_0A00;
    p1_req = 1'b1; p1_addr = 32'h0000_0B00;
    for (int k = 0; k < 4; k++) begin
      s_gnt = 1'b1; s_recv = 1'b0; p0_ack = 1'b0; p1_ack = 1'b0;
      gnt_q.push_back(order[k]);
      #3;
      checks++;
      if (s_addr !== (order[k] ? 32'h0000_0B00 : 32'h0000_0A00)) begin
        errors++;
        $display("FAIL contend_addr%0d: s_addr=%h required %h", k, s_addr,
                 order[k] ? 32'h0000_0B00 : 32'h0000_0A00);
      end
      cyc();
      s_gnt = 1'b1; s_recv = 1'b1; s_rdata = 32'hC0DE_0000 + 32'(k); p0_ack = 1'b1; p1_ack = 1'b1;
      rsp_q.push_back('{port: order[k], rdata: 32'hC0DE_0000 + 32'(k), err: 1'b0});
      #3;
      checks++;
      if (s_req !== 1'b0 || s_ack !== 1'b1) begin
        errors++;
        $display("FAIL contend_rsp%0d: s_req=%0b s_ack=%0b required 0 1", k, s_req, s_ack);
      end
      cyc();
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_response_hold();
    p0_req = 1'b1; p0_addr = 32'h0000_0100; s_gnt = 1'b1;
    gnt_q.push_back(1'b0);
    cyc();
    p0_req = 1'b0; s_gnt = 1'b0;
    cyc();
    s_recv = 1'b1; s_error = 1'b1; s_rdata = 32'hBAD0_0001;
    for (int c = 0; c < 4; c++) begin
      p0_ack = (c == 3);
      if (c == 3) rsp_q.push_back('{port: 1'b0, rdata: 32'hBAD0_0001, err: 1'b1});
      #3;
      checks++;
      if (p0_error !== 1'b1 || p0_recv !== 1'b1 || s_ack !== (c == 3) || p1_error !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: p0_error=%0b p0_recv=%0b s_ack=%0b p1_error=%0b required 1 1 %0b 0",
                 c, p0_error, p0_recv, s_ack, p1_error, (c == 3));
      end
      cyc();
    end
    clear_inputs();
    #3;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: busy=%0b required 0", busy);
    end
    cyc();
  endtask

  task automatic test_withdrawn();
    p0_req = 1'b1; p0_addr = 32'h0000_0200;
    #3;
    checks++;
    if (s_req !== 1'b1 || busy !== 1'b0 || p0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wd_req: s_req=%0b busy=%0b p0_gnt=%0b required 1 0 0", s_req, busy, p0_gnt);
    end
    cyc();
    p0_req = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b1 || s_req !== 1'b0 || s_addr !== 32'h0) begin
      errors++;
      $display("FAIL wd_drop: busy=%0b s_req=%0b s_addr=%h required 1 0 0", busy, s_req, s_addr);
    end
    cyc();
    s_gnt = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wd_idle: busy=%0b p0_gnt=%0b p1_gnt=%0b required 0 0 0", busy, p0_gnt, p1_gnt);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset_mid_rsp();
    p1_req = 1'b1; p1_addr = 32'h0000_0300; s_gnt = 1'b1;
    gnt_q.push_back(1'b1);
    cyc();
    p1_req = 1'b0; s_gnt = 1'b0; s_recv = 1'b1; s_rdata = 32'h5555_AAAA;
    #2;
    checks++;
    if (busy !== 1'b1 || p1_recv !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: busy=%0b p1_recv=%0b required 1 1", busy, p1_recv);
    end
    g_resetn = 1'b0;
    p1_ack = 1'b1; p0_req = 1'b1; s_gnt = 1'b1;
    #1;
    checks++;
    if ({busy, s_req, s_ack, p0_gnt, p1_gnt, p0_recv, p1_recv} !== 7'b0 || p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: busy/s_req/s_ack/gnt/recv=%b p1_rdata=%h required 0000000 0",
               {busy, s_req, s_ack, p0_gnt, p1_gnt, p0_recv, p1_recv}, p1_rdata);
    end
    cyc();
    clear_inputs();
    g_resetn = 1'b1;
    cyc();
    p1_req = 1'b1; p1_addr = 32'h0000_0304; s_gnt = 1'b1;
    gnt_q.push_back(1'b1);
    #3;
    checks++;
    if (p1_gnt !== 1'b1 || s_addr !== 32'h0000_0304) begin
      errors++;
      $display("FAIL rst_regrant: p1_gnt=%0b s_addr=%h required 1 00000304", p1_gnt, s_addr);
    end
    cyc();
    p1_req = 1'b0; s_gnt = 1'b0; s_recv = 1'b1; s_rdata = 32'h7777_0001; p1_ack = 1'b1;
    rsp_q.push_back('{port: 1'b1, rdata: 32'h7777_0001, err: 1'b0});
    cyc();
    clear_inputs();
    cyc();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    g_resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read_p1();
    test_stalled_lock();
    test_contention();
    test_response_hold();
    test_withdrawn();
    test_reset_mid_rsp();
    cyc();
    checks++;
    if (gnt_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: gnt_q=%0d rsp_q=%0d required 0 0", gnt_q.size(), rsp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
